// File: rtl/rgb_fade_pwm_if.sv
// rgb_fade_pwm_if: level requests in, PWM drives and fading flag out; master = pattern source, slave = fader
interface rgb_fade_pwm_if;
  logic in_r, in_g, in_b;
  logic led_r, led_g, led_b;
  logic fading;
  modport master (output in_r, in_g, in_b, input led_r, led_g, led_b, fading);
  modport slave (input in_r, in_g, in_b, output led_r, led_g, led_b, fading);
endinterface

// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm: ramps three LED channels toward 0/MAX_DUTY and drives them with glitch-free PWM (clk, rst, io: in_r/g/b -> led_r/g/b, fading)
module rgb_fade_pwm #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned FADE_DIV = 1024,
  parameter int unsigned MAX_DUTY = 255,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic rst,
  rgb_fade_pwm_if.slave io
);
  localparam int unsigned DW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAXD = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] TOP = '1;
  localparam logic [DW-1:0] DLAST = DW'(FADE_DIV - 1);
  logic [2:0] in_q, in_d, led_q, led_d;
  logic fading_q, fading_d, step;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0][PWM_BITS-1:0] duty_q, duty_d, duty_act_q, duty_act_d, target;
  always_comb begin
    in_d = {io.in_b, io.in_g, io.in_r};
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    step = div_cnt_q == DLAST;
    div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
    fading_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      target[i] = in_q[i] ? MAXD : '0;
      duty_d[i] = !step ? duty_q[i] :
                  duty_q[i] < target[i] ? duty_q[i] + 1'b1 :
                  duty_q[i] > target[i] ? duty_q[i] - 1'b1 : duty_q[i];
      // shadow copy taken on the last count so a new duty starts on a period boundary
      duty_act_d[i] = pwm_cnt_q == TOP ? duty_q[i] : duty_act_q[i];
      led_d[i] = (duty_act_q[i] > pwm_cnt_q) ^ ACTIVE_LOW;
      fading_d = fading_d | (duty_q[i] != target[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      duty_q <= '0;
      duty_act_q <= '0;
      led_q <= {3{ACTIVE_LOW}};
      fading_q <= 1'b0;
    end else begin
      in_q <= in_d;
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      duty_q <= duty_d;
      duty_act_q <= duty_act_d;
      led_q <= led_d;
      fading_q <= fading_d;
    end
  end
  assign io.led_r = led_q[0];
  assign io.led_g = led_q[1];
  assign io.led_b = led_q[2];
  assign io.fading = fading_q;
endmodule

// File: tb/tb_rgb_fade_pwm.sv
// tb_rgb_fade_pwm: random and directed stimulus on two fader configurations checked against a cycle model
module tb_rgb_fade_pwm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_r = 1'b1, in_g = 1'b1, in_b = 1'b1;
  int n_cmp = 0, n_err = 0;
  int fdv[2] = '{4, 1};
  int mxv[2] = '{15, 8};
  int alv[2] = '{0, 1};
  int mt[2];
  int mduty[2][3], mact[2][3], mled[2][3], mfade[2], mq[2][3];
  rgb_fade_pwm_if bus0 ();
  rgb_fade_pwm_if bus1 ();
  assign bus0.in_r = in_r;
  assign bus0.in_g = in_g;
  assign bus0.in_b = in_b;
  assign bus1.in_r = in_r;
  assign bus1.in_g = in_g;
  assign bus1.in_b = in_b;
  rgb_fade_pwm #(.PWM_BITS(4), .FADE_DIV(4), .MAX_DUTY(15), .ACTIVE_LOW(1'b0)) u0 (.clk(clk), .rst(rst), .io(bus0.slave));
  rgb_fade_pwm #(.PWM_BITS(4), .FADE_DIV(1), .MAX_DUTY(8), .ACTIVE_LOW(1'b1)) u1 (.clk(clk), .rst(rst), .io(bus1.slave));
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic model_tick();
    int ins[3];
    ins = '{int'(in_r), int'(in_g), int'(in_b)};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mt[k] = 0;
        mfade[k] = 0;
        for (int c = 0; c < 3; c++) begin
          mq[k][c] = 0; mduty[k][c] = 0; mact[k][c] = 0; mled[k][c] = alv[k];
        end
      end else begin
        int pc, tgt, f;
        bit st;
        pc = mt[k] % 16;
        st = (mt[k] % fdv[k]) == fdv[k] - 1;
        f = 0;
        for (int c = 0; c < 3; c++) begin
          tgt = mq[k][c] != 0 ? mxv[k] : 0;
          mled[k][c] = (mact[k][c] > pc) ? 1 - alv[k] : alv[k];
          if (mduty[k][c] != tgt) f = 1;
          if (pc == 15) mact[k][c] = mduty[k][c];
          if (st && mduty[k][c] < tgt) mduty[k][c]++;
          else if (st && mduty[k][c] > tgt) mduty[k][c]--;
          mq[k][c] = ins[c];
        end
        mfade[k] = f;
        mt[k]++;
      end
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check("u0.led_r", int'(bus0.led_r), mled[0][0]);
    check("u0.led_g", int'(bus0.led_g), mled[0][1]);
    check("u0.led_b", int'(bus0.led_b), mled[0][2]);
    check("u0.fading", int'(bus0.fading), mfade[0]);
    check("u1.led_r", int'(bus1.led_r), mled[1][0]);
    check("u1.led_g", int'(bus1.led_g), mled[1][1]);
    check("u1.led_b", int'(bus1.led_b), mled[1][2]);
    check("u1.fading", int'(bus1.fading), mfade[1]);
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic width_check(string tag, int exp0, int exp1);
    int on0 = 0, on1 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      on0 += int'(bus0.led_r);
      on1 += int'(!bus1.led_r);
    end
    check({tag, ".u0"}, on0, exp0);
    check({tag, ".u1"}, on1, exp1);
  endtask
  initial begin
    run(3);
    check("reset_fading", int'(bus0.fading | bus1.fading), 0);
    check("reset_led_u1", int'({bus1.led_r, bus1.led_g, bus1.led_b}), 7);
    rst = 1'b0; in_g = 1'b0; in_b = 1'b0;
    run(80);
    check("ramp_up_done", int'(bus0.fading), 0);
    width_check("sat_width", 15, 8);
    in_r = 1'b0;
    run(80);
    width_check("off_width", 0, 0);
    in_r = 1'b1;
    run(30);
    in_r = 1'b0;
    run(40);
    in_g = 1'b1;
    run(38);
    rst = 1'b1;
    cycle();
    check("mid_rst_led_g", int'(bus0.led_g), 0);
    rst = 1'b0;
    run(90);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) in_r = ~in_r;
      if ($urandom_range(0, 29) == 0) in_g = ~in_g;
      if ($urandom_range(0, 9) == 0) in_b = ~in_b;
      rst = $urandom_range(0, 399) == 0;
      cycle();
    end
    rst = 1'b0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
